// File: rtl/weight_loader.sv
// Streams num_words SRAM words starting at base_addr into the row-lane input FIFO,
// with a one-word skid register to absorb fifo_full. Optional macro: WEIGHT_LOADER_ROW_MASK_EN.
module weight_loader #(
   parameter int unsigned row    = 8,
   parameter int unsigned bw     = 4,
   parameter int unsigned addr_w = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [addr_w-1:0]   base_addr,
   input  logic [addr_w:0]     num_words,
`ifdef WEIGHT_LOADER_ROW_MASK_EN
   input  logic [row-1:0]      row_mask,
`endif
   output logic                sram_cen,
   output logic                sram_wen,
   output logic [addr_w-1:0]   sram_addr,
   input  logic [row*bw-1:0]   sram_q,
   input  logic                fifo_full,
   output logic [row-1:0]      fifo_wr,
   output logic [row*bw-1:0]   fifo_in,
   output logic                busy,
   output logic                done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [addr_w:0] CntOne = 1;

   logic [1:0]          state_q, state_d;
   logic [addr_w-1:0]   base_q, base_d;
   logic [addr_w:0]     num_q, num_d;
   logic [addr_w:0]     issued_q, issued_d;
   logic [addr_w:0]     written_q, written_d;
   logic                pend_q, pend_d;
   logic                hold_vld_q, hold_vld_d;
   logic [row*bw-1:0]   hold_q, hold_d;
   logic [row-1:0]      wr_lanes;

   logic issue;
   logic xfer;
   logic capture;
   logic last;

`ifdef WEIGHT_LOADER_ROW_MASK_EN
   logic [row-1:0] mask_q, mask_d;
   assign wr_lanes = mask_q;
`else
   assign wr_lanes = '1;
`endif

   // A read is only launched when its data is guaranteed a home next cycle.
   assign issue   = (state_q == StRun) && !fifo_full && !hold_vld_q && (issued_q < num_q);
   assign xfer    = (state_q == StRun) && !fifo_full && (hold_vld_q || pend_q);
   assign capture = (state_q == StRun) && fifo_full && pend_q;
   assign last    = xfer && ((written_q + CntOne) == num_q);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      issued_d   = issued_q;
      written_d  = written_q;
      pend_d     = 1'b0;
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
      mask_d     = mask_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               base_d    = base_addr;
               num_d     = num_words;
               issued_d  = '0;
               written_d = '0;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
               mask_d    = row_mask;
`endif
               state_d   = (num_words == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            pend_d = issue;
            if (issue) begin
               issued_d = issued_q + CntOne;
            end
            if (capture) begin
               hold_vld_d = 1'b1;
               hold_d     = sram_q;
            end
            if (xfer) begin
               written_d = written_q + CntOne;
               if (hold_vld_q) begin
                  hold_vld_d = 1'b0;
               end
            end
            if (last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         pend_q     <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
         mask_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         written_q  <= written_d;
         pend_q     <= pend_d;
         hold_vld_q <= hold_vld_d;
         hold_q     <= hold_d;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
         mask_q     <= mask_d;
`endif
      end
   end

   // Address arithmetic truncates to addr_w, so loads wrap past the top of SRAM.
   assign sram_addr = base_q + issued_q[addr_w-1:0];
   assign sram_cen  = ~issue;
   assign sram_wen  = 1'b1;
   assign fifo_wr   = xfer ? wr_lanes : '0;

   always_comb begin
      fifo_in = '0;
      if (hold_vld_q) begin
         fifo_in = hold_q;
      end else if (pend_q) begin
         fifo_in = sram_q;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader: a small SRAM model plus a monitor that
// logs reads, FIFO beats and done pulses for comparison against hand-listed expectations.
module tb_weight_loader;

   localparam int unsigned Row   = 8;
   localparam int unsigned Bw    = 4;
   localparam int unsigned AddrW = 11;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [AddrW-1:0]  base_addr;
   logic [AddrW:0]    num_words;
   logic [Row-1:0]    row_mask;
   logic              sram_cen;
   logic              sram_wen;
   logic [AddrW-1:0]  sram_addr;
   logic [Row*Bw-1:0] sram_q;
   logic              fifo_full;
   logic [Row-1:0]    fifo_wr;
   logic [Row*Bw-1:0] fifo_in;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [AddrW-1:0]  rd_addr[$];
   logic [Row*Bw-1:0] wr_data[$];
   logic [Row-1:0]    wr_mask[$];
   int                wr_cyc[$];
   int                done_cyc[$];

   always #5 clk = ~clk;

   weight_loader #(
      .row    (Row),
      .bw     (Bw),
      .addr_w (AddrW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
`ifdef WEIGHT_LOADER_ROW_MASK_EN
      .row_mask  (row_mask),
`endif
      .sram_cen  (sram_cen),
      .sram_wen  (sram_wen),
      .sram_addr (sram_addr),
      .sram_q    (sram_q),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_in   (fifo_in),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [31:0] pat(input logic [10:0] a);
      return {5'h15, a, 5'h0A, a};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      sram_q <= !sram_cen ? pat(sram_addr) : 32'hDEADBEEF;
   end

   always @(negedge clk) begin
      if (sram_cen === 1'b0) rd_addr.push_back(sram_addr);
      if (fifo_wr !== '0 && fifo_wr !== 'x) begin
         wr_data.push_back(fifo_in);
         wr_mask.push_back(fifo_wr);
         wr_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (fifo_full) check("no_wr_while_full", 64'(fifo_wr), 64'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_addr.delete();
      wr_data.delete();
      wr_mask.delete();
      wr_cyc.delete();
      done_cyc.delete();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cen"},  64'(sram_cen), 64'h1);
      check({tag, "_wen"},  64'(sram_wen), 64'h1);
      check({tag, "_addr"}, 64'(sram_addr), 64'h0);
      check({tag, "_wr"},   64'(fifo_wr), 64'h0);
      check({tag, "_in"},   64'(fifo_in), 64'h0);
      check({tag, "_busy"}, 64'(busy), 64'h0);
      check({tag, "_done"}, 64'(done), 64'h0);
   endtask

   // full_pat bit k drives fifo_full in cycle start+k; restart_off re-pulses start mid-load.
   task automatic run_load(input logic [10:0] base, input logic [11:0] num, input logic [7:0] mask,
                           input logic [31:0] full_pat, input int restart_off, output int c);
      clear_logs();
      step();
      start     = 1'b1;
      base_addr = base;
      num_words = num;
      row_mask  = mask;
      c         = cyc;
      for (int k = 1; k <= 60; k++) begin
         step();
         start     = (k == restart_off);
         if (k == restart_off) begin
            base_addr = 11'h200;
            num_words = 12'd5;
         end
         fifo_full = (k < 32) ? full_pat[k[4:0]] : 1'b0;
         if (k == 1) check("busy_after_start", 64'(busy), 64'h1);
         if (done_cyc.size() != 0) break;
      end
      if (done_cyc.size() == 0) check("done_timeout", 64'h0, 64'h1);
      start     = 1'b0;
      fifo_full = 1'b0;
      step();
      check("busy_after_done", 64'(busy), 64'h0);
      check("done_count", 64'(done_cyc.size()), 64'h1);
   endtask

   task automatic check_run(input string tag, input logic [10:0] exp_a[4], input int n,
                            input logic [7:0] exp_mask);
      check({tag, "_nrd"}, 64'(rd_addr.size()), 64'(n));
      check({tag, "_nwr"}, 64'(wr_data.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < rd_addr.size()) check({tag, "_addr"}, 64'(rd_addr[i]), 64'(exp_a[i]));
         if (i < wr_data.size()) begin
            check({tag, "_data"}, 64'(wr_data[i]), 64'(pat(exp_a[i])));
            check({tag, "_mask"}, 64'(wr_mask[i]), 64'(exp_mask));
         end
      end
      if (n > 0 && wr_cyc.size() == n && done_cyc.size() > 0)
         check({tag, "_done_after_last"}, 64'(done_cyc[0]), 64'(wr_cyc[n-1] + 1));
   endtask

   initial begin
      logic [10:0] ea[4];
      int c;

      reset     = 1'b1;
      start     = 1'b0;
      fifo_full = 1'b0;
      base_addr = '0;
      num_words = '0;
      row_mask  = 8'hFF;
      repeat (3) step();
      check_idle("reset");
      reset = 1'b0;

      // Straight four-word load.
      ea = '{11'h010, 11'h011, 11'h012, 11'h013};
      run_load(11'h010, 12'd4, 8'hFF, 32'h0, -1, c);
      check_run("basic", ea, 4, 8'hFF);
      if (wr_cyc.size() > 0) check("basic_first_wr", 64'(wr_cyc[0] - c), 64'd2);
      if (done_cyc.size() > 0) check("basic_done_cyc", 64'(done_cyc[0] - c), 64'd6);

      // fifo_full for three cycles right after the second read.
      ea = '{11'h040, 11'h041, 11'h042, 11'h043};
      run_load(11'h040, 12'd4, 8'hFF, 32'h38, -1, c);
      check_run("stall", ea, 4, 8'hFF);
      if (wr_cyc.size() == 4) begin
         check("stall_w1_cyc", 64'(wr_cyc[1] - c), 64'd6);
         check("stall_w2_cyc", 64'(wr_cyc[2] - c), 64'd8);
      end
      if (done_cyc.size() > 0) check("stall_done_cyc", 64'(done_cyc[0] - c), 64'd10);

      // Address wrap at the top of SRAM.
      ea = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
      run_load(11'h7FE, 12'd4, 8'hFF, 32'h0, -1, c);
      check_run("wrap", ea, 4, 8'hFF);

      // Zero-length load.
      run_load(11'h123, 12'd0, 8'hFF, 32'h0, -1, c);
      check("zero_nrd", 64'(rd_addr.size()), 64'h0);
      check("zero_nwr", 64'(wr_data.size()), 64'h0);
      if (done_cyc.size() > 0) check("zero_done_cyc", 64'(done_cyc[0] - c), 64'd1);

      // Second start while busy must be ignored.
      ea = '{11'h100, 11'h101, 11'h102, 11'h000};
      run_load(11'h100, 12'd3, 8'hFF, 32'h0, 2, c);
      check_run("restart", ea, 3, 8'hFF);
      if (done_cyc.size() > 0) check("restart_done_cyc", 64'(done_cyc[0] - c), 64'd5);

      // Reset during the second FIFO beat of an eight-word load.
      clear_logs();
      step();
      start     = 1'b1;
      base_addr = 11'h300;
      num_words = 12'd8;
      c         = cyc;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      check_idle("midrst");
      reset = 1'b0;
      repeat (10) step();
      check("midrst_nwr", 64'(wr_data.size()), 64'd2);
      check("midrst_no_done", 64'(done_cyc.size()), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);

`ifdef WEIGHT_LOADER_ROW_MASK_EN
      ea = '{11'h020, 11'h021, 11'h022, 11'h023};
      run_load(11'h020, 12'd4, 8'h0F, 32'h0, -1, c);
      check_run("mask", ea, 4, 8'h0F);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter row, default 8: number of FIFO lanes (array rows).
REQ-002 SHALL have parameter bw, default 4: bits per weight lane.
REQ-003 SHALL have parameter addr_w, default 11: SRAM address width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port base_addr  input  addr_w  first SRAM word address, sampled on accepted start.
REQ-008 SHALL have port num_words  input  addr_w+1  SRAM words to transfer, sampled on accepted start.
REQ-009 SHALL have port sram_cen  output  1  active-low SRAM chip enable (read strobe).
REQ-010 SHALL have port sram_wen  output  1  active-low SRAM write enable, tied 1.
REQ-011 SHALL have port sram_addr  output  addr_w  SRAM read address.
REQ-012 SHALL have port sram_q  input  row*bw  SRAM read data, valid one cycle after sram_cen=0.
REQ-013 SHALL have port fifo_full  input  1  any-lane-full indication from downstream input FIFO.
REQ-014 SHALL have port fifo_wr  output  row  per-lane write strobe to the input FIFO.
REQ-015 SHALL have port fifo_in  output  row*bw  write data; lane i on bits [(i+1)*bw-1:i*bw].
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the load completes.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when last word is written to FIFO, DONE->IDLE after one cycle.
REQ-019 SHALL ignore start while busy=1; start with num_words=0 SHALL go IDLE->DONE, zero SRAM reads.
REQ-020 SHALL, in RUN, issue a read (sram_cen=0) in a cycle only if fifo_full=0, hold register empty, words-issued < num_words.
REQ-021 SHALL drive sram_addr = base_addr + issued_count, modulo 2^addr_w (wraps at top of SRAM).
REQ-022 SHALL, in the cycle after a read, pass sram_q to fifo_in with fifo_wr asserted if fifo_full=0; else capture sram_q into a one-word hold register.
REQ-023 SHALL, while hold register is full, assert fifo_wr with hold data when fifo_full=0, clear hold at that edge, and issue no new read that cycle.
REQ-024 SHALL sustain one word per cycle when fifo_full stays 0; first fifo_wr two cycles after start.
REQ-025 SHALL never write the FIFO when fifo_full=1 and never drop or duplicate a word.
REQ-026 SHALL assert fifo_wr on all lanes together (subject to REQ-033); fifo_wr=0 whenever no word is transferred.
REQ-027 SHALL pulse done in the cycle after the final FIFO write; busy falls with done.

Reset
REQ-028 SHALL on reset enter IDLE: sram_cen=1, sram_wen=1, sram_addr=0, fifo_wr=0, fifo_in=0, busy=0, done=0, hold empty, counters 0.
REQ-029 SHALL on reset mid-load abort immediately: pending SRAM data discarded, no further fifo_wr, no done pulse.
REQ-030 SHALL give reset priority over start in the same cycle.

Configuration
REQ-031 SHALL support macro WEIGHT_LOADER_ROW_MASK_EN.
REQ-032 SHALL, when defined, add port row_mask  input  row, sampled on accepted start, held for the load.
REQ-033 SHALL, when defined, drive fifo_wr = row_mask on each transfer (masked lanes not written); when undefined, fifo_wr = all ones on each transfer, no row_mask port.

Verification
REQ-034 SHALL test: base_addr=0x010, num_words=4, fifo_full=0 -> reads 0x010..0x013 on consecutive cycles, four fifo_wr=8'hFF beats matching SRAM, done one cycle after last beat.
REQ-035 SHALL test: fifo_full=1 for 3 cycles on the cycle after the 2nd read -> word 2 held, no write while full, all words delivered in order once fifo_full=0.
REQ-036 SHALL test: base_addr=0x7FE, num_words=4 -> addresses 0x7FE,0x7FF,0x000,0x001.
REQ-037 SHALL test: num_words=0 -> no sram_cen=0, done pulses one cycle after start; start while busy -> ignored.
REQ-038 SHALL test: reset asserted after 2nd fifo_wr of an 8-word load -> all outputs at reset values next cycle, no done.
REQ-039 SHALL test with WEIGHT_LOADER_ROW_MASK_EN, row_mask=8'h0F -> each beat fifo_wr=8'h0F.
